multicycle_datapath: RTL and testbench
======================================

Name: multicycle_datapath

Overview:
Next-generation RV32I-subset integer datapath. It adds a controlling FSM, an instruction-fetch handshake, a program counter, and immediate (I-type) operations around the instruction register, register file and ALU. Each instruction executes in FETCH/DECODE/EXECUTE/WRITEBACK steps. It is parametrised in data width, register count and reset PC. Debug/writeback ports are exposed for verification.

Parameters:
WIDTH, 32, data/PC width in bits (>=32; instructions always 32 bits)
NREGS, 32, architectural register count (power of 2, 2..32); rs/rd index uses low $clog2(NREGS) bits of the field
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-low (rst==0 at a rising edge resets)
imem_req  output  1  instruction fetch request
imem_addr  output  WIDTH  fetch address (current PC)
imem_ack  input  1  fetch data valid this cycle
imem_rdata  input  32  instruction word, sampled when imem_req && imem_ack
wb_en  output  1  register write this cycle (never for rd==0)
wb_addr  output  $clog2(NREGS)  written register index
wb_data  output  WIDTH  written value
retired  output  1  one-cycle pulse per completed instruction
halted  output  1  illegal instruction trapped; sticky until reset
pc  output  WIDTH  current PC

Behaviour:
- Reset (rst==0 at an edge): state=FETCH, PC=RESET_PC, all registers=0, IR=0, halted=0. wb_en, retired and imem_req are 0 in the cycle after reset. Reset takes priority over everything, in any state, including mid-handshake.
- FETCH: imem_req=1, imem_addr=PC. Request is held until imem_ack is sampled 1. On that edge, IR<=imem_rdata and the FSM moves to DECODE. imem_ack while imem_req==0 is ignored.
- DECODE: A<=reg[rs1], B<=reg[rs2]. imm = IR[31:20] sign-extended to WIDTH. Decode opcode and funct fields. An illegal instruction goes to TRAP; otherwise the FSM moves to EXECUTE.
- Legal set:
  - Opcode 0x33: funct3/funct7 in {ADD,SUB(f7=0x20,f3=0),SLL,SLT,SLTU,XOR,SRL,SRA(f7=0x20,f3=5),OR,AND}. funct7 must be 0x00, except 0x20 for SUB/SRA.
  - Opcode 0x13: ADDI,SLTI,SLTIU,XORI,ORI,ANDI,SLLI,SRLI,SRAI. Shift forms require IR[31:25] to be 0x00, or 0x20 for SRAI.
  - Anything else is illegal.
- EXECUTE: second operand = B for opcode 0x33, imm for opcode 0x13. Result latched into R.
  - Arithmetic wraps modulo 2^WIDTH.
  - Shift amount = low $clog2(WIDTH) bits of the operand. SRA is arithmetic.
  - SLT is signed, SLTU unsigned; result is 1 or 0.
- WRITEBACK: wb_en=1 iff rd!=0, with wb_addr=rd and wb_data=R. reg[rd]<=R. retired=1 for this cycle. PC<=PC+4 (wraps). Next state FETCH.
- Register x0 always reads 0. Writes to x0 are suppressed, but the instruction still retires.
- Minimum latency: 4 cycles per instruction with zero-wait ack. Each ack wait cycle adds 1.
- TRAP: halted=1, imem_req=0, no writes, PC frozen at the faulting instruction. Only reset exits TRAP.
- Read-after-write: a WRITEBACK value is visible to the next instruction's DECODE. No forwarding is needed, because stages are sequential.

Optional Feature:
MULTICYCLE_DATAPATH_INSTRET_EN:
- Defined: adds output instret [63:0]. It resets to 0, increments by 1 on each retired pulse, wraps at 2^64, and does not increment in TRAP.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- ADDI x1,x0,5 (0x00500093) with ack same cycle -> 4 cycles later wb_en=1, wb_addr=1, wb_data=5, retired=1, pc=RESET_PC+4.
- Then ADDI x2,x0,-3 (0xFFD00113), ADD x3,x1,x2 (0x002081B3), SUB x4,x1,x2 (0x40208233) -> x2=0xFFFFFFFD, x3=2, x4=8.
- SRAI x5,x2,1 (0x40115293) -> wb_data=0xFFFFFFFE. ADDI x0,x0,7 (0x00700013) -> wb_en=0, retired=1, x0 reads 0 afterwards.
- Hold imem_ack=0 for 3 cycles in FETCH -> imem_req and imem_addr stable throughout; instruction retires 7 cycles after FETCH entry.
- Word 0xFFFFFFFF -> halted=1 two cycles after ack, imem_req stays 0, pc frozen. Assert rst=0 for one edge -> halted=0, pc=RESET_PC, FETCH resumes.
- Assert rst=0 during a fetch wait -> next cycle imem_req=0, pc=RESET_PC, no wb_en/retired. Then ADDI retires normally. With the macro defined, instret counts only post-reset retirements.

Source files
------------

// File: rtl/multicycle_datapath.sv
// Multicycle RV32I-subset integer datapath: FETCH/DECODE/EXECUTE/WRITEBACK FSM with ALU and regfile.
// Optional MULTICYCLE_DATAPATH_INSTRET_EN adds a 64-bit retired-instruction counter output.
module multicycle_datapath #(
    parameter int unsigned    WIDTH    = 32,
    parameter int unsigned    NREGS    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [WIDTH-1:0]         imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    output logic                     wb_en,
    output logic [$clog2(NREGS)-1:0] wb_addr,
    output logic [WIDTH-1:0]         wb_data,
    output logic                     retired,
    output logic                     halted,
    output logic [WIDTH-1:0]         pc
`ifdef MULTICYCLE_DATAPATH_INSTRET_EN
    ,
    output logic [63:0]              instret
`endif
);

    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned SW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExecute,
        StWriteback,
        StTrap
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      ir_q;
    logic [WIDTH-1:0] a_q, b_q, r_q;
    logic             boot_q;
    logic [WIDTH-1:0] regs_q [NREGS];

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [AW-1:0]    rs1, rs2, rd;
    logic             is_rtype;
    logic             legal;
    logic             fetch_go;
    logic [WIDTH-1:0] imm, op_b, alu_res, rs1_val, rs2_val;
    logic [SW-1:0]    shamt;

    assign opcode   = ir_q[6:0];
    assign funct3   = ir_q[14:12];
    assign funct7   = ir_q[31:25];
    assign rd       = ir_q[7 +: AW];
    assign rs1      = ir_q[15 +: AW];
    assign rs2      = ir_q[20 +: AW];
    assign is_rtype = (opcode == 7'h33);
    assign imm      = {{(WIDTH-12){ir_q[31]}}, ir_q[31:20]};
    assign rs1_val  = (rs1 == '0) ? '0 : regs_q[rs1];
    assign rs2_val  = (rs2 == '0) ? '0 : regs_q[rs2];
    assign op_b     = is_rtype ? b_q : imm;
    assign shamt    = op_b[SW-1:0];

    always_comb begin
        legal = 1'b0;
        if (opcode == 7'h33) begin
            legal = (funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
        end else if (opcode == 7'h13) begin
            unique case (funct3)
                3'd1:    legal = (funct7 == 7'h00);
                3'd5:    legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                default: legal = 1'b1;
            endcase
        end
    end

    // funct7[5] selects SUB (R-type only) and SRA/SRAI; legality already restricts funct7.
    always_comb begin
        alu_res = '0;
        unique case (funct3)
            3'd0: alu_res = (is_rtype && funct7[5]) ? a_q - op_b : a_q + op_b;
            3'd1: alu_res = a_q << shamt;
            3'd2: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(op_b))};
            3'd3: alu_res = {{(WIDTH-1){1'b0}}, (a_q < op_b)};
            3'd4: alu_res = a_q ^ op_b;
            3'd5: alu_res = funct7[5] ? WIDTH'($signed(a_q) >>> shamt) : a_q >> shamt;
            3'd6: alu_res = a_q | op_b;
            3'd7: alu_res = a_q & op_b;
            default: alu_res = '0;
        endcase
    end

    // boot_q holds off the first request for one cycle after reset.
    assign fetch_go = (state_q == StFetch) && !boot_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        imem_req = 1'b0;
        wb_en    = 1'b0;
        retired  = 1'b0;
        unique case (state_q)
            StFetch: begin
                imem_req = fetch_go;
                if (fetch_go && imem_ack) state_d = StDecode;
            end
            StDecode:    state_d = legal ? StExecute : StTrap;
            StExecute:   state_d = StWriteback;
            StWriteback: begin
                wb_en   = (rd != '0);
                retired = 1'b1;
                pc_d    = pc_q + WIDTH'(4);
                state_d = StFetch;
            end
            StTrap:      state_d = StTrap;
            default:     state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            boot_q  <= 1'b1;
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            boot_q  <= 1'b0;
            if (fetch_go && imem_ack) ir_q <= imem_rdata;
            if (state_q == StDecode) begin
                a_q <= rs1_val;
                b_q <= rs2_val;
            end
            if (state_q == StExecute) r_q <= alu_res;
            if (wb_en) regs_q[rd] <= r_q;
        end
    end

`ifdef MULTICYCLE_DATAPATH_INSTRET_EN
    logic [63:0] instret_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            instret_q <= '0;
        end else if (retired) begin
            instret_q <= instret_q + 64'd1;
        end
    end
    assign instret = instret_q;
`endif

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign wb_addr   = rd;
    assign wb_data   = r_q;
    assign halted    = (state_q == StTrap);

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed self-checking bench for multicycle_datapath: ALU ops, x0, ack waits, trap and reset.
module tb_multicycle_datapath;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NREGS = 32;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        retired;
    logic        halted;
    logic [31:0] pc;
`ifdef MULTICYCLE_DATAPATH_INSTRET_EN
    logic [63:0] instret;
    logic [63:0] exp_instret;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] exp_pc;

    multicycle_datapath #(
        .WIDTH    (WIDTH),
        .NREGS    (NREGS),
        .RESET_PC (RPC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .retired    (retired),
        .halted     (halted),
        .pc         (pc)
`ifdef MULTICYCLE_DATAPATH_INSTRET_EN
        ,
        .instret    (instret)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One reset edge, then check the state seen in the cycle that follows it.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_pc = RPC;
`ifdef MULTICYCLE_DATAPATH_INSTRET_EN
        exp_instret = '0;
        check_eq("rst_instret", instret, 64'd0);
`endif
        check_eq("rst_req", imem_req, 1'b0);
        check_eq("rst_pc", pc, RPC);
        check_eq("rst_wb_en", wb_en, 1'b0);
        check_eq("rst_retired", retired, 1'b0);
        check_eq("rst_halted", halted, 1'b0);
    endtask

    task automatic run_instr(input logic [31:0] instr, input int waits, input logic exp_we,
                             input logic [4:0] exp_rd, input logic [31:0] exp_data);
        int cnt;
        int guard;
        guard = 0;
        while (!imem_req && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq("fetch_req", imem_req, 1'b1);
        check_eq("fetch_addr", imem_addr, exp_pc);
        cnt = 0;
        repeat (waits) begin
            imem_ack = 1'b0;
            @(negedge clk);
            cnt++;
            check_eq("wait_req", imem_req, 1'b1);
            check_eq("wait_addr", imem_addr, exp_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = instr;
        @(negedge clk);
        cnt++;
        imem_ack   = 1'b0;
        imem_rdata = 32'hFFFF_FFFF;
        check_eq("dec_req", imem_req, 1'b0);
        @(negedge clk);
        cnt++;
        check_eq("ex_retired", retired, 1'b0);
        @(negedge clk);
        cnt++;
        check_eq("wb_retired", retired, 1'b1);
        check_eq("wb_en", wb_en, exp_we);
        check_eq("latency", cnt, waits + 3);
        if (exp_we) begin
            check_eq("wb_addr", wb_addr, exp_rd);
            check_eq("wb_data", wb_data, exp_data);
        end
        @(negedge clk);
        exp_pc = exp_pc + 32'd4;
        check_eq("next_pc", pc, exp_pc);
        check_eq("post_retired", retired, 1'b0);
`ifdef MULTICYCLE_DATAPATH_INSTRET_EN
        exp_instret = exp_instret + 64'd1;
        check_eq("instret", instret, exp_instret);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_pc = RPC;
`ifdef MULTICYCLE_DATAPATH_INSTRET_EN
        exp_instret = '0;
`endif
        repeat (2) @(negedge clk);
        do_reset();

        run_instr(32'h0050_0093, 0, 1'b1, 5'd1,  32'd5);          // addi x1,x0,5
        run_instr(32'hFFD0_0113, 0, 1'b1, 5'd2,  32'hFFFF_FFFD);  // addi x2,x0,-3
        run_instr(32'h0020_81B3, 1, 1'b1, 5'd3,  32'd2);          // add  x3,x1,x2
        run_instr(32'h4020_8233, 0, 1'b1, 5'd4,  32'd8);          // sub  x4,x1,x2
        run_instr(32'h4011_5293, 0, 1'b1, 5'd5,  32'hFFFF_FFFE);  // srai x5,x2,1
        run_instr(32'h0070_0013, 0, 1'b0, 5'd0,  32'd0);          // addi x0,x0,7
        run_instr(32'h0010_0313, 0, 1'b1, 5'd6,  32'd1);          // addi x6,x0,1
        run_instr(32'h0011_23B3, 3, 1'b1, 5'd7,  32'd1);          // slt  x7,x2,x1
        run_instr(32'h0011_3433, 0, 1'b1, 5'd8,  32'd0);          // sltu x8,x2,x1
        run_instr(32'h0030_94B3, 0, 1'b1, 5'd9,  32'h14);         // sll  x9,x1,x3
        run_instr(32'h0031_5533, 2, 1'b1, 5'd10, 32'h3FFF_FFFF);  // srl  x10,x2,x3
        run_instr(32'h0020_C5B3, 0, 1'b1, 5'd11, 32'hFFFF_FFF8);  // xor  x11,x1,x2
        run_instr(32'h0040_F633, 0, 1'b1, 5'd12, 32'd0);          // and  x12,x1,x4
        run_instr(32'h0040_E6B3, 0, 1'b1, 5'd13, 32'd13);         // or   x13,x1,x4
        run_instr(32'hFFF0_B713, 0, 1'b1, 5'd14, 32'd1);          // sltiu x14,x1,-1
        run_instr(32'hFFF1_4793, 0, 1'b1, 5'd15, 32'd2);          // xori x15,x2,-1
        run_instr(32'h0041_5813, 0, 1'b1, 5'd16, 32'h0FFF_FFFF);  // srli x16,x2,4
        run_instr(32'h01F0_9893, 0, 1'b1, 5'd17, 32'h8000_0000);  // slli x17,x1,31

        // Illegal word traps; later acks are ignored and pc stays on the faulting fetch.
        while (!imem_req) @(negedge clk);
        check_eq("trap_addr", imem_addr, exp_pc);
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check_eq("trap_dec_halted", halted, 1'b0);
        @(negedge clk);
        check_eq("trap_halted", halted, 1'b1);
        check_eq("trap_req", imem_req, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check_eq("trap_pc", pc, exp_pc);
            check_eq("trap_sticky", halted, 1'b1);
            check_eq("trap_req_hold", imem_req, 1'b0);
            check_eq("trap_wb_en", wb_en, 1'b0);
            check_eq("trap_retired", retired, 1'b0);
        end
        imem_ack = 1'b0;
        do_reset();
        run_instr(32'h0002_8A33, 0, 1'b1, 5'd20, 32'd0);          // add x20,x5,x0 after reset

        // Reset during a fetch wait.
        while (!imem_req) @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        check_eq("midfetch_req", imem_req, 1'b1);
        do_reset();
        run_instr(32'h0090_0093, 1, 1'b1, 5'd1, 32'd9);           // addi x1,x0,9
        run_instr(32'h0000_81B3, 0, 1'b1, 5'd3, 32'd9);           // add  x3,x1,x0

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
